// File: rtl/hpram_cmd_arbiter.sv
// Shares the HyperRAM command port between the camera write channel and the
// display read channel: fixed-length bursts, command gap, and read timeout.
module hpram_cmd_arbiter #(
    parameter int ADDR_WIDTH  = 22,
    parameter int DATA_WIDTH  = 32,
    parameter int BURST_WORDS = 16,
    parameter int CMD_GAP     = 4,
    parameter int RD_TIMEOUT  = 255
) (
    input  logic                    I_clk,
    input  logic                    I_rst,
    input  logic                    I_init_calib,
    input  logic                    I_wr_req,
    input  logic [ADDR_WIDTH-1:0]   I_wr_addr,
    input  logic [DATA_WIDTH-1:0]   I_wr_data,
    input  logic [DATA_WIDTH/8-1:0] I_wr_mask,
    output logic                    O_wr_pop,
    output logic                    O_wr_ack,
    input  logic                    I_rd_req,
    input  logic                    I_rd_urgent,
    input  logic [ADDR_WIDTH-1:0]   I_rd_addr,
    output logic                    O_rd_ack,
    output logic                    O_rd_valid,
    output logic [DATA_WIDTH-1:0]   O_rd_data,
    output logic                    O_cmd,
    output logic                    O_cmd_en,
    output logic [ADDR_WIDTH-1:0]   O_addr,
    output logic [DATA_WIDTH-1:0]   O_wr_data,
    output logic [DATA_WIDTH/8-1:0] O_data_mask,
    input  logic                    I_rd_data_valid,
    input  logic [DATA_WIDTH-1:0]   I_rd_data,
    output logic                    O_busy,
    output logic                    O_timeout
);

    localparam int BEAT_W = $clog2(BURST_WORDS) + 1;

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_WR_BURST = 2'd1;
    localparam logic [1:0] S_RD_WAIT  = 2'd2;
    localparam logic [1:0] S_GAP      = 2'd3;

    logic [1:0]            state;
    logic [BEAT_W-1:0]     beat;
    logic [3:0]            gap_cnt;
    logic [9:0]            timer;
    logic                  last_wr;
    logic                  timeout_q;
    logic                  rd_valid_q;
    logic [DATA_WIDTH-1:0] rd_data_q;

    logic wr_grant;
    logic rd_grant;
    logic rd_beat_in;
    logic last_rd_beat;

    // Urgent read beats a tie; otherwise the side not served last time wins.
    always_comb begin
        wr_grant = 1'b0;
        rd_grant = 1'b0;
        if (!I_rst && I_init_calib && state == S_IDLE) begin
            if (I_wr_req && I_rd_req) begin
                if (I_rd_urgent || last_wr) rd_grant = 1'b1;
                else                        wr_grant = 1'b1;
            end else begin
                wr_grant = I_wr_req;
                rd_grant = I_rd_req;
            end
        end
    end

    assign rd_beat_in   = (state == S_RD_WAIT) && I_rd_data_valid;
    assign last_rd_beat = rd_beat_in && (beat == BEAT_W'(BURST_WORDS - 1));

    assign O_cmd_en    = wr_grant || rd_grant;
    assign O_cmd       = wr_grant;
    assign O_addr      = wr_grant ? I_wr_addr : (rd_grant ? I_rd_addr : '0);
    assign O_wr_ack    = wr_grant;
    assign O_rd_ack    = rd_grant;
    assign O_wr_pop    = wr_grant || (state == S_WR_BURST);
    assign O_wr_data   = O_wr_pop ? I_wr_data : '0;
    assign O_data_mask = O_wr_pop ? I_wr_mask : '0;
    assign O_busy      = (state != S_IDLE);
    assign O_timeout   = timeout_q;
    assign O_rd_valid  = rd_valid_q;
    assign O_rd_data   = rd_data_q;

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            state      <= S_IDLE;
            beat       <= '0;
            gap_cnt    <= '0;
            timer      <= '0;
            last_wr    <= 1'b0;
            timeout_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= rd_beat_in;
            if (rd_beat_in) rd_data_q <= I_rd_data;

            if (!I_init_calib) begin
                // Lost calibration abandons any burst in flight.
                state   <= S_IDLE;
                beat    <= '0;
                gap_cnt <= '0;
                timer   <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (wr_grant) begin
                            state   <= S_WR_BURST;
                            beat    <= BEAT_W'(1);
                            last_wr <= 1'b1;
                        end else if (rd_grant) begin
                            state   <= S_RD_WAIT;
                            beat    <= '0;
                            timer   <= '0;
                            last_wr <= 1'b0;
                        end
                    end
                    S_WR_BURST: begin
                        beat <= beat + BEAT_W'(1);
                        if (beat == BEAT_W'(BURST_WORDS - 1)) begin
                            state   <= S_GAP;
                            gap_cnt <= '0;
                        end
                    end
                    S_RD_WAIT: begin
                        timer <= timer + 10'd1;
                        if (rd_beat_in) beat <= beat + BEAT_W'(1);
                        if (last_rd_beat) begin
                            state   <= S_GAP;
                            gap_cnt <= '0;
                        end else if (timer + 10'd1 == 10'(RD_TIMEOUT)) begin
                            timeout_q <= 1'b1;
                            state     <= S_GAP;
                            gap_cnt   <= '0;
                        end
                    end
                    default: begin
                        // CMD_GAP idle cycles plus the exit cycle back to IDLE.
                        if (gap_cnt == 4'(CMD_GAP)) state <= S_IDLE;
                        else                        gap_cnt <= gap_cnt + 4'd1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hpram_cmd_arbiter.sv
// Directed bench for hpram_cmd_arbiter with grant and read-beat scoreboards.
module tb_hpram_cmd_arbiter;

    localparam int AW  = 22;
    localparam int DW  = 32;
    localparam int MW  = DW / 8;
    localparam int BW  = 16;
    localparam int GAP = 4;
    localparam int TMO = 255;

    logic          clk = 1'b0;
    logic          I_rst, I_init_calib;
    logic          I_wr_req, I_rd_req, I_rd_urgent;
    logic [AW-1:0] I_wr_addr, I_rd_addr;
    logic [DW-1:0] I_wr_data;
    logic [MW-1:0] I_wr_mask;
    logic          O_wr_pop, O_wr_ack, O_rd_ack, O_rd_valid;
    logic [DW-1:0] O_rd_data, O_wr_data;
    logic          O_cmd, O_cmd_en, O_busy, O_timeout;
    logic [AW-1:0] O_addr;
    logic [MW-1:0] O_data_mask;
    logic          I_rd_data_valid;
    logic [DW-1:0] I_rd_data;

    always #5 clk = ~clk;

    hpram_cmd_arbiter #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .BURST_WORDS(BW),
        .CMD_GAP    (GAP),
        .RD_TIMEOUT (TMO)
    ) dut (
        .I_clk          (clk),
        .I_rst          (I_rst),
        .I_init_calib   (I_init_calib),
        .I_wr_req       (I_wr_req),
        .I_wr_addr      (I_wr_addr),
        .I_wr_data      (I_wr_data),
        .I_wr_mask      (I_wr_mask),
        .O_wr_pop       (O_wr_pop),
        .O_wr_ack       (O_wr_ack),
        .I_rd_req       (I_rd_req),
        .I_rd_urgent    (I_rd_urgent),
        .I_rd_addr      (I_rd_addr),
        .O_rd_ack       (O_rd_ack),
        .O_rd_valid     (O_rd_valid),
        .O_rd_data      (O_rd_data),
        .O_cmd          (O_cmd),
        .O_cmd_en       (O_cmd_en),
        .O_addr         (O_addr),
        .O_wr_data      (O_wr_data),
        .O_data_mask    (O_data_mask),
        .I_rd_data_valid(I_rd_data_valid),
        .I_rd_data      (I_rd_data),
        .O_busy         (O_busy),
        .O_timeout      (O_timeout)
    );

    typedef struct { logic cmd; logic [AW-1:0] addr; } grant_t;
    typedef struct { logic [DW-1:0] d; int cyc; } rd_t;

    grant_t gq[$];
    rd_t    rq[$];
    grant_t mg;
    rd_t    mr;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int wr_idx   = 0;
    int cmd_cnt  = 0;
    int pop_cnt  = 0;
    int rd_vcnt  = 0;
    int last_cmd = -1;
    bit mon_en   = 1'b0;

    int mem_beats = 16;
    int mem_delay = 10;
    bit stray_req = 1'b0;
    int rd_seq    = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (O_wr_pop) wr_idx <= wr_idx + 1;

    // Write requester: first-word-fall-through FIFO with a counting pattern.
    assign I_wr_data = {16'hD00D, wr_idx[15:0]};
    assign I_wr_mask = wr_idx[3:0] ^ 4'h5;

    always @(negedge clk) begin
        if (I_rst) last_cmd = -1;
        if (mon_en) begin
            if (O_cmd_en) begin
                cmd_cnt++;
                if (gq.size() == 0) begin
                    check("cmd_en_unexpected", O_cmd_en, 0);
                end else begin
                    mg = gq.pop_front();
                    check("cmd_dir", O_cmd, mg.cmd);
                    check("cmd_addr", O_addr, mg.addr);
                    check("wr_ack", O_wr_ack, mg.cmd);
                    check("rd_ack", O_rd_ack, !mg.cmd);
                end
                if (last_cmd >= 0) check("cmd_spacing_ge21", (cyc - last_cmd) >= (BW + GAP + 1), 1);
                last_cmd = cyc;
            end else begin
                check("ack_without_cmd", {O_wr_ack, O_rd_ack}, 0);
            end
            if (O_wr_pop) begin
                pop_cnt++;
                check("wr_data", O_wr_data, {16'hD00D, wr_idx[15:0]});
                check("wr_mask", O_data_mask, wr_idx[3:0] ^ 4'h5);
            end else begin
                check("wr_data_idle", O_wr_data, 0);
                check("wr_mask_idle", O_data_mask, 0);
            end
            if (O_rd_valid) begin
                rd_vcnt++;
                if (rq.size() == 0) begin
                    check("rd_valid_unexpected", O_rd_valid, 0);
                end else begin
                    mr = rq.pop_front();
                    check("rd_data", O_rd_data, mr.d);
                    check("rd_latency", cyc - mr.cyc, 1);
                end
            end
        end
    end

    // Memory model: answers each read ack with mem_beats beats after mem_delay cycles.
    initial begin
        I_rd_data_valid = 1'b0;
        I_rd_data       = '0;
        forever begin
            @(negedge clk);
            if (O_rd_ack && !I_rst) begin
                repeat (mem_delay) @(posedge clk);
                for (int i = 0; i < mem_beats; i++) begin
                    @(posedge clk); #1;
                    I_rd_data_valid = 1'b1;
                    I_rd_data       = 32'hBE00_0000 + rd_seq;
                    rq.push_back(rd_t'{I_rd_data, cyc});
                    rd_seq++;
                end
                @(posedge clk); #1;
                I_rd_data_valid = 1'b0;
            end else if (stray_req) begin
                @(posedge clk); #1;
                I_rd_data_valid = 1'b1;
                I_rd_data       = 32'h5742_A7ED;
                @(posedge clk); #1;
                I_rd_data_valid = 1'b0;
                stray_req       = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wait_ack(input bit is_wr, input string tag);
        int n;
        bit seen;
        n    = 0;
        seen = 1'b0;
        while (n < 400 && !seen) begin
            @(negedge clk);
            seen = is_wr ? O_wr_ack : O_rd_ack;
            n++;
        end
        check(tag, seen, 1);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (O_busy && n < 600);
        check(tag, O_busy, 0);
    endtask

    task automatic wait_cmds(input int target, input string tag);
        int n;
        n = 0;
        while (cmd_cnt < target && n < 3000) begin
            tick();
            n++;
        end
        check(tag, cmd_cnt, target);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, tg, rv0, rv1;
        I_rst        = 1'b1;
        I_init_calib = 1'b1;
        I_wr_req     = 1'b1;
        I_rd_req     = 1'b0;
        I_rd_urgent  = 1'b0;
        I_wr_addr    = 22'h000100;
        I_rd_addr    = '0;
        tick();
        mon_en = 1'b1;
        repeat (2) tick();

        // Reset with a pending request: no grant, everything quiet.
        @(negedge clk);
        check("rst_cmd_en", O_cmd_en, 0);
        check("rst_wr_pop", O_wr_pop, 0);
        check("rst_busy", O_busy, 0);
        check("rst_timeout", O_timeout, 0);
        check("rst_rd_valid", O_rd_valid, 0);
        check("rst_addr", O_addr, 0);
        tick();
        I_wr_req = 1'b0;
        I_rst    = 1'b0;
        tick();

        // Single write burst.
        gq.push_back(grant_t'{1'b1, 22'h000100});
        pop_cnt  = 0;
        I_wr_req = 1'b1;
        wait_ack(1'b1, "t1_wr_ack");
        tick();
        I_wr_req = 1'b0;
        for (int i = 1; i < BW; i++) begin
            @(negedge clk);
            check("t1_pop_consecutive", O_wr_pop, 1);
        end
        @(negedge clk);
        check("t1_pop_end", O_wr_pop, 0);
        check("t1_in_gap", O_busy, 1);
        wait_idle("t1_idle");
        check("t1_pop_count", pop_cnt, BW);

        // Single read burst, 16 beats after 10 cycles.
        mem_beats = 16;
        mem_delay = 10;
        tick();
        gq.push_back(grant_t'{1'b0, 22'h000200});
        I_rd_addr = 22'h000200;
        rv0       = rd_vcnt;
        I_rd_req  = 1'b1;
        wait_ack(1'b0, "t2_rd_ack");
        tick();
        I_rd_req = 1'b0;
        wait_idle("t2_idle");
        check("t2_rd_valid_count", rd_vcnt - rv0, BW);
        check("t2_rq_empty", rq.size(), 0);
        check("t2_timeout", O_timeout, 0);

        // Both requesters held: round-robin starting with write.
        mem_delay = 2;
        tick();
        c0        = cmd_cnt;
        I_wr_addr = 22'h000300;
        I_rd_addr = 22'h000400;
        gq.push_back(grant_t'{1'b1, 22'h000300});
        gq.push_back(grant_t'{1'b0, 22'h000400});
        gq.push_back(grant_t'{1'b1, 22'h000300});
        gq.push_back(grant_t'{1'b0, 22'h000400});
        I_wr_req = 1'b1;
        I_rd_req = 1'b1;
        wait_cmds(c0 + 4, "t3_rr_grants");
        I_wr_req = 1'b0;
        I_rd_req = 1'b0;
        wait_idle("t3_rr_idle");
        check("t3_rr_gq_empty", gq.size(), 0);

        // Urgent read wins every tie.
        tick();
        c0          = cmd_cnt;
        I_rd_urgent = 1'b1;
        for (int i = 0; i < 3; i++) gq.push_back(grant_t'{1'b0, 22'h000400});
        I_wr_req = 1'b1;
        I_rd_req = 1'b1;
        wait_cmds(c0 + 3, "t3_urgent_grants");
        I_wr_req    = 1'b0;
        I_rd_req    = 1'b0;
        I_rd_urgent = 1'b0;
        wait_idle("t3_urgent_idle");
        check("t3_urgent_gq_empty", gq.size(), 0);
        check("t3_rq_empty", rq.size(), 0);

        // Read with one beat missing: timeout 255 cycles after cmd_en.
        mem_beats = 15;
        mem_delay = 10;
        tick();
        gq.push_back(grant_t'{1'b0, 22'h000500});
        I_rd_addr = 22'h000500;
        rv0       = rd_vcnt;
        I_rd_req  = 1'b1;
        wait_ack(1'b0, "t4_rd_ack");
        tg = cyc;
        tick();
        I_rd_req = 1'b0;
        while (cyc < tg + TMO) @(negedge clk);
        check("t4_timeout_before", O_timeout, 0);
        check("t4_busy_before", O_busy, 1);
        @(negedge clk);
        check("t4_timeout_at_255", O_timeout, 1);
        wait_idle("t4_idle");
        check("t4_rd_valid_count", rd_vcnt - rv0, BW - 1);
        check("t4_timeout_sticky", O_timeout, 1);
        rv1       = rd_vcnt;
        stray_req = 1'b1;
        repeat (6) @(negedge clk);
        check("t4_stray_ignored", rd_vcnt - rv1, 0);
        check("t4_stray_done", stray_req, 0);

        // Calibration lost during write beat 5.
        mem_beats = 16;
        tick();
        gq.push_back(grant_t'{1'b1, 22'h000600});
        I_wr_addr = 22'h000600;
        I_wr_req  = 1'b1;
        wait_ack(1'b1, "t5_wr_ack");
        repeat (5) @(posedge clk);
        #1;
        I_init_calib = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("t5_pop_stopped", O_wr_pop, 0);
        check("t5_busy_cleared", O_busy, 0);
        c0 = cmd_cnt;
        repeat (25) @(negedge clk);
        check("t5_no_cmd_uncal", cmd_cnt - c0, 0);
        tick();
        gq.push_back(grant_t'{1'b1, 22'h000600});
        I_init_calib = 1'b1;
        wait_ack(1'b1, "t5_regrant");
        tick();
        I_wr_req = 1'b0;
        wait_idle("t5_idle");

        // Reset in the middle of a read wait.
        mem_beats = 0;
        tick();
        gq.push_back(grant_t'{1'b0, 22'h000700});
        I_rd_addr = 22'h000700;
        I_rd_req  = 1'b1;
        wait_ack(1'b0, "t6_rd_ack");
        repeat (20) @(negedge clk);
        check("t6_busy_pre", O_busy, 1);
        check("t6_timeout_pre", O_timeout, 1);
        tick();
        I_rst = 1'b1;
        tick();
        @(negedge clk);
        check("t6_rst_busy", O_busy, 0);
        check("t6_rst_timeout", O_timeout, 0);
        check("t6_rst_strobes", {O_cmd_en, O_cmd, O_wr_ack, O_rd_ack, O_wr_pop, O_rd_valid}, 0);
        check("t6_rst_addr", O_addr, 0);
        check("t6_rst_rd_data", O_rd_data, 0);
        check("t6_rst_wr_data", {O_wr_data, O_data_mask}, 0);
        I_rd_req = 1'b0;
        tick();
        I_rst = 1'b0;
        repeat (3) tick();
        check("t6_idle_after", O_busy, 0);
        check("final_gq_empty", gq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/hpram_cmd_arbiter.md
Name: hpram_cmd_arbiter

Overview:
- Shares the single HyperRAM memory-interface command port between two requesters: the camera write channel and the display read channel.
- Issues fixed-length bursts, streams write beats, collects read beats, enforces a minimum command gap and times out lost reads.
- Sits between the frame-buffer DMA logic and the HyperRAM memory interface. Runs in the dma_clk domain.

Parameters:
ADDR_WIDTH, 22, memory word-address width
DATA_WIDTH, 32, memory data width
BURST_WORDS, 16, beats per burst, 2..64
CMD_GAP, 4, idle cycles required after a burst ends before the next cmd_en, 0..15
RD_TIMEOUT, 255, max cycles from read cmd_en to final beat, 1..1023

Ports:
I_clk  in  1  dma clock (dma_clk domain)
I_rst  in  1  synchronous reset, active-high
I_init_calib  in  1  memory calibrated; no grants while low
I_wr_req  in  1  write burst request, held until O_wr_ack
I_wr_addr  in  ADDR_WIDTH  write burst start address
I_wr_data  in  DATA_WIDTH  write beat, first-word-fall-through
I_wr_mask  in  DATA_WIDTH/8  write byte mask for the current beat
O_wr_pop  out  1  consume current write beat
O_wr_ack  out  1  one-cycle pulse: write burst accepted
I_rd_req  in  1  read burst request, held until O_rd_ack
I_rd_urgent  in  1  display FIFO low; read wins a tie
I_rd_addr  in  ADDR_WIDTH  read burst start address
O_rd_ack  out  1  one-cycle pulse: read burst accepted
O_rd_valid  out  1  read beat valid
O_rd_data  out  DATA_WIDTH  read beat
O_cmd  out  1  1 = write, 0 = read
O_cmd_en  out  1  command strobe
O_addr  out  ADDR_WIDTH  command address
O_wr_data  out  DATA_WIDTH  write beat to memory
O_data_mask  out  DATA_WIDTH/8  byte mask to memory
I_rd_data_valid  in  1  read beat valid from memory
I_rd_data  in  DATA_WIDTH  read beat from memory
O_busy  out  1  state != IDLE
O_timeout  out  1  sticky read-timeout flag; cleared only by I_rst

Behaviour:
- Reset, applied while I_rst is high at a clock edge:
  - state = IDLE; beat, gap and timeout counters = 0; last_grant = READ.
  - All outputs are 0.
- States: IDLE, WR_BURST, RD_WAIT, GAP.
- Grant is evaluated only in IDLE with I_init_calib = 1.
  - Only one request present: grant it.
  - Both present and I_rd_urgent = 1: read wins.
  - Both present otherwise: round-robin, the side opposite last_grant wins.
  - On grant, update last_grant.
- Write grant, same cycle as the grant:
  - O_cmd_en = 1, O_cmd = 1, O_addr = I_wr_addr, O_wr_ack = 1.
  - Beat 0 goes out: O_wr_data = I_wr_data, O_data_mask = I_wr_mask, O_wr_pop = 1.
  - Next state WR_BURST with beat = 1.
- WR_BURST:
  - Each cycle, I_wr_data and I_wr_mask pass combinationally to O_wr_data and O_data_mask; O_wr_pop = 1; beat increments.
  - After beat BURST_WORDS-1 goes out, go to GAP.
  - Exactly BURST_WORDS pops per burst; no stalls permitted. The requester asserts I_wr_req only when it holds >= BURST_WORDS words.
- Read grant, same cycle as the grant:
  - O_cmd_en = 1, O_cmd = 0, O_addr = I_rd_addr, O_rd_ack = 1.
  - Next state RD_WAIT; beat = 0, timer = 0.
- RD_WAIT:
  - Each I_rd_data_valid registers I_rd_data onto O_rd_data and pulses O_rd_valid 1 cycle later (1-cycle latency); beat increments.
  - After the BURST_WORDS-th beat, go to GAP.
  - Timer increments every cycle. If timer reaches RD_TIMEOUT before the last beat: set O_timeout, go to GAP. Later stray beats are ignored.
- GAP:
  - Hold for CMD_GAP cycles, then go to IDLE.
  - CMD_GAP = 0: GAP lasts 1 cycle.
  - Minimum cmd_en spacing = burst length + CMD_GAP + 1.
- I_rd_data_valid outside RD_WAIT: ignored, no O_rd_valid.
- I_init_calib falls mid-operation: next cycle go to IDLE.
  - All strobes 0; no further pops.
  - Partial burst abandoned; the requester re-requests.
- O_cmd_en is never asserted in any cycle other than the grant cycle.
- O_wr_data and O_data_mask are 0 outside write beats.
- A request deasserted before ack is simply not granted; no ack is given later.
- Simultaneous ack of write and read never occurs.

Test Plan:
- Reset, then calib = 1, I_wr_req with addr 0x000100, BURST_WORDS = 16 → one cmd_en with cmd = 1 and addr 0x000100, O_wr_ack pulse, 16 consecutive pops with data matching, cmd_en spacing >= 21.
- Read addr 0x000200, memory returns 16 valid beats after 10 cycles → 16 O_rd_valid pulses each 1 cycle after the input, data equal, O_timeout = 0.
- Both requests held continuously, I_rd_urgent = 0 → grants alternate W, R, W, R (last_grant = READ after reset, so write goes first); with I_rd_urgent = 1 → R every grant.
- Read with only 15 beats returned, RD_TIMEOUT = 255 → O_timeout = 1 at cycle 255 after cmd_en, FSM returns to IDLE after the gap, a later 16th beat produces no O_rd_valid.
- I_init_calib dropped at write beat 5 → pops stop the next cycle, O_busy = 0, no cmd_en until calib = 1 again.
- I_rst asserted mid-RD_WAIT → next cycle all outputs 0, state IDLE, O_timeout cleared.
